// File: rtl/icache_if.sv
// Direct-mapped instruction cache for the IF1/IF2 fetch front end with whole-line refill.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STAT_EN.
module icache_if #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] if1_addr,
  input  logic              if1_en,
  input  logic              hold,
  input  logic              kill,
  input  logic              inv,
  output logic [31:0]       if2_inst,
  output logic              if2_valid,
  output logic              inst_sram_miss,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
`ifdef ICACHE_STAT_EN
  output logic [31:0]       stat_hit_o,
  output logic [31:0]       stat_miss_o,
`endif
  input  logic              mem_ready
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  // state  | meaning
  // IDLE   | lookup on addr_q; a miss launches a refill
  // REFILL | one word per accepted beat, sequential from word 0
  // DONE   | line installed; stall held one more cycle, pending inv applied on exit
  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  logic [ADDR_W-1:2]   addr_q;
  logic                req_v_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [31:0]         data_mem [LINES*WORDS];
  state_t              state;
  logic [OFFSET_W-1:0] cnt;
  logic [OFFSET_W-1:0] cnt_nxt;
  logic [TAG_W-1:0]    fill_tag;
  logic [INDEX_W-1:0]  fill_idx;
  logic                inv_pend;
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_word;
  logic                hit;
  logic                idle;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^if1_addr[1:0];

  assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx  = addr_q[OFFSET_W+2 +: INDEX_W];
  assign req_word = addr_q[2 +: OFFSET_W];
  assign cnt_nxt  = cnt + 1'b1;

  assign idle           = (state == IDLE);
  assign hit            = req_v_q & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);
  assign if2_valid      = hit & idle;
  assign if2_inst       = if2_valid ? data_mem[{req_idx, req_word}] : 32'd0;
  assign inst_sram_miss = (req_v_q & ~hit & idle) | ~idle;

  // kill wins over a new request; under hold the address is frozen
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      req_v_q <= 1'b0;
    end else if (!hold) begin
      addr_q  <= if1_addr[ADDR_W-1:2];
      req_v_q <= if1_en & ~kill;
    end else if (kill) begin
      req_v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      valid_q  <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
      inv_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inv) valid_q <= '0;
          if (req_v_q && !hit) begin
            state    <= REFILL;
            cnt      <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {req_tag, req_idx, {OFFSET_W{1'b0}}, 2'b00};
            fill_tag <= req_tag;
            fill_idx <= req_idx;
          end
        end
        REFILL: begin
          if (inv) inv_pend <= 1'b1;
          if (mem_ready) begin
            cnt      <= cnt_nxt;
            mem_addr <= {fill_tag, fill_idx, cnt_nxt, 2'b00};
            if (cnt == '1) begin
              valid_q[fill_idx] <= 1'b1;
              mem_req           <= 1'b0;
              state             <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          // a deferred fence.i also drops the line just installed
          if (inv || inv_pend) begin
            valid_q  <= '0;
            inv_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) begin
      data_mem[{fill_idx, cnt}] <= mem_rdata;
      if (cnt == '1) tag_mem[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_hit_o  <= '0;
      stat_miss_o <= '0;
    end else begin
      if (if2_valid) stat_hit_o <= stat_hit_o + 32'd1;
      if (idle && req_v_q && !hit) stat_miss_o <= stat_miss_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_if.sv
// Self-checking bench for icache_if: directed scenarios plus randomized fetches
// checked against a line-level cache model and a functional memory image.
module tb_icache_if;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if1_addr;
  logic        if1_en, hold, kill, inv;
  logic [31:0] if2_inst;
  logic        if2_valid, inst_sram_miss, mem_req;
  logic [31:0] mem_addr, mem_rdata;
  logic        mem_ready;
`ifdef ICACHE_STAT_EN
  logic [31:0] stat_hit_o, stat_miss_o;
`endif

  icache_if dut (
    .clk(clk), .rstn(rstn), .if1_addr(if1_addr), .if1_en(if1_en), .hold(hold),
    .kill(kill), .inv(inv), .if2_inst(if2_inst), .if2_valid(if2_valid),
    .inst_sram_miss(inst_sram_miss), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
`ifdef ICACHE_STAT_EN
    .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o),
`endif
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = memf(mem_addr);

  int n_err = 0;
  int n_checks = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  bit use_rand = 1'b0;
  int pat[$];

  // Cache model: which memory line each index currently holds.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[9:4]] && (m_tag[a[9:4]] == a[31:10]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a whole refill from the miss cycle; returns whether inv was pulsed.
  task automatic refill(input logic [31:0] a, input bit kill_first, input int inv_beat,
                        output bit inv_seen);
    logic [31:0] base;
    int b, cyc;
    bit r, inv_done;
    base = {a[31:4], 4'h0};
    inv_seen = 1'b0;
    inv_done = 1'b0;
    exp_misses++;
    kill = kill_first;
    tick();
    kill = 1'b0;
    b = 0;
    cyc = 0;
    while (b < 4 && cyc < 100) begin
      if (pat.size() > 0) r = pat.pop_front() != 0;
      else if (use_rand) r = $urandom_range(0, 3) != 0;
      else r = 1'b1;
      mem_ready = r;
      if (b == inv_beat && !inv_done) begin
        inv = 1'b1;
        inv_done = 1'b1;
        inv_seen = 1'b1;
      end else begin
        inv = 1'b0;
      end
      chk("refill_mem_req", {31'd0, mem_req}, 32'd1);
      chk("refill_mem_addr", mem_addr, base + 32'(4 * b));
      chk("refill_miss", {31'd0, inst_sram_miss}, 32'd1);
      chk("refill_valid", {31'd0, if2_valid}, 32'd0);
      tick();
      if (r) b++;
      cyc++;
    end
    mem_ready = 1'b0;
    inv = 1'b0;
    chk("refill_beats", 32'(b), 32'd4);
    chk("done_mem_req", {31'd0, mem_req}, 32'd0);
    chk("done_miss", {31'd0, inst_sram_miss}, 32'd1);
    chk("done_valid", {31'd0, if2_valid}, 32'd0);
    tick();
    m_valid[a[9:4]] = 1'b1;
    m_tag[a[9:4]] = a[31:10];
    if (inv_seen) model_clear();
  endtask

  task automatic do_access(input logic [31:0] a, input bit kill_first, input int inv_beat,
                           input bit inv_idle);
    bit exp_hit, inv_seen;
    int guard;
    if1_addr = a;
    if1_en = 1'b1;
    hold = 1'b0;
    kill = 1'b0;
    tick();
    if1_en = 1'b0;
    exp_hit = model_hit(a);
    chk("lookup_valid", {31'd0, if2_valid}, {31'd0, exp_hit});
    chk("lookup_miss", {31'd0, inst_sram_miss}, {31'd0, !exp_hit});
    if (!exp_hit) begin
      hold = 1'b1;
      refill(a, kill_first, inv_beat, inv_seen);
      if (kill_first) begin
        chk("killed_valid", {31'd0, if2_valid}, 32'd0);
        chk("killed_miss", {31'd0, inst_sram_miss}, 32'd0);
        hold = 1'b0;
        return;
      end
      guard = 0;
      while (!model_hit(a) && guard < 3) begin
        chk("reinv_miss", {31'd0, inst_sram_miss}, 32'd1);
        chk("reinv_valid", {31'd0, if2_valid}, 32'd0);
        refill(a, 1'b0, -1, inv_seen);
        guard++;
      end
      hold = 1'b0;
    end
    chk("hit_valid", {31'd0, if2_valid}, 32'd1);
    chk("hit_inst", if2_inst, memf(a));
    chk("hit_mem_req", {31'd0, mem_req}, 32'd0);
    chk("hit_miss", {31'd0, inst_sram_miss}, 32'd0);
    exp_hits++;
    if (inv_idle) begin
      inv = 1'b1;
      tick();
      inv = 1'b0;
      model_clear();
      chk("inv_idle_valid", {31'd0, if2_valid}, 32'd0);
      chk("inv_idle_miss", {31'd0, inst_sram_miss}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int ib;
    model_clear();
    rstn = 1'b0;
    if1_addr = '0; if1_en = 1'b0; hold = 1'b0; kill = 1'b0; inv = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst", if2_inst, 32'd0);
    chk("rst_valid", {31'd0, if2_valid}, 32'd0);
    chk("rst_miss", {31'd0, inst_sram_miss}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rstn = 1'b1;
    tick();

    // cold miss, hit stream, conflict
    do_access(32'h0000_1004, 1'b0, -1, 1'b0);
    do_access(32'h0000_1000, 1'b0, -1, 1'b0);
    do_access(32'h0000_1008, 1'b0, -1, 1'b0);
    do_access(32'h0000_100C, 1'b0, -1, 1'b0);
    do_access(32'h0000_2000, 1'b0, -1, 1'b0);
    do_access(32'h0000_1000, 1'b0, -1, 1'b0);

    // backpressure
    pat = '{1, 0, 0, 1, 0, 1, 1};
    do_access(32'h0000_3010, 1'b0, -1, 1'b0);
    do_access(32'h0000_301C, 1'b0, -1, 1'b0);

    // inv mid-refill, inv in IDLE, kill while request is refilling
    do_access(32'h0000_4020, 1'b0, 2, 1'b0);
    do_access(32'h0000_4024, 1'b0, -1, 1'b1);
    do_access(32'h0000_4028, 1'b1, -1, 1'b0);
    do_access(32'h0000_4028, 1'b0, -1, 1'b0);

    use_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(1, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      ib = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_access(a, $urandom_range(0, 7) == 0, ib, $urandom_range(0, 7) == 0);
    end

`ifdef ICACHE_STAT_EN
    chk("stat_hit", stat_hit_o, 32'(exp_hits));
    chk("stat_miss", stat_miss_o, 32'(exp_misses));
`endif

    // kill with hold low drops the request
    if1_addr = 32'h0000_5000; if1_en = 1'b1; kill = 1'b1; hold = 1'b0;
    tick();
    if1_en = 1'b0; kill = 1'b0;
    chk("kill_valid", {31'd0, if2_valid}, 32'd0);
    chk("kill_miss", {31'd0, inst_sram_miss}, 32'd0);
    chk("kill_mem_req", {31'd0, mem_req}, 32'd0);

    // reset in the middle of a refill
    do_access(32'h0000_1000, 1'b0, -1, 1'b0);
    if1_addr = 32'h0000_1C90; if1_en = 1'b1;
    tick();
    if1_en = 1'b0; hold = 1'b1;
    tick();
    mem_ready = 1'b1;
    tick();
    rstn = 1'b0;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_miss", {31'd0, inst_sram_miss}, 32'd0);
    chk("midrst_valid", {31'd0, if2_valid}, 32'd0);
    mem_ready = 1'b0; hold = 1'b0;
    tick();
    rstn = 1'b1;
    model_clear();
    use_rand = 1'b0;
    do_access(32'h0000_1000, 1'b0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
